// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS pipeline.
// The stage latches the ID->EX bus and computes the ALU result and the data-SRAM request.
// It forwards the writeback target back to ID for bypassing.
// A 32-step restoring divider executes DIV/DIVU and holds the pipeline until HI/LO is ready.

// Invariant checker for the execute stage; carries no design logic.
module ex_stage_chk (
  input logic       clk,
  input logic       rst,
  input logic       stallreq_for_ex,
  input logic       hi_we,
  input logic       lo_we,
  input logic       data_sram_en,
  input logic [3:0] data_sram_wen
);

  // A HI/LO write only happens in the cycle the EX hold is released.
  a_hilo_release: assert property (@(posedge clk) disable iff (rst)
    hi_we |-> !stallreq_for_ex);

  // HI and LO are always written together.
  a_hilo_pair: assert property (@(posedge clk) disable iff (rst)
    hi_we == lo_we);

  // Byte enables never escape a disabled SRAM request.
  a_wen_gated: assert property (@(posedge clk) disable iff (rst)
    (data_sram_wen != 4'h0) |-> data_sram_en);

endmodule

module ex_stage #(
  parameter int ID_TO_EX_WD  = 159,
  parameter int EX_TO_MEM_WD = 76,
  parameter int EX_TO_RF_WD  = 38,
  parameter int StallBus     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBus-1:0]     stall,
  output logic                    stallreq_for_ex,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
  output logic [65:0]             ex_to_hilo_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata
);

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [5:0] FUNCT_DIV  = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU = 6'h1B;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Two's-complement magnitude of a 32-bit value (0x80000000 maps onto itself as unsigned).
  function automatic logic [31:0] abs32(input logic [31:0] v);
    logic [31:0] r;
    if (v[31]) begin
      r = ~v + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // One restoring-division step on the {remainder, quotient} pair.
  // The shifted remainder can reach 33 bits, so the trial subtraction is 33 bits wide.
  function automatic logic [63:0] restore_step(input logic [63:0] rq, input logic [31:0] d);
    logic [32:0] shifted;
    logic [32:0] trial;
    logic [63:0] r;
    shifted = {rq[63:32], rq[31]};
    trial   = shifted - {1'b0, d};
    if (!trial[32]) begin
      r = {trial[31:0], rq[30:0], 1'b1};
    end else begin
      r = {shifted[31:0], rq[30:0], 1'b0};
    end
    return r;
  endfunction

  // ---------------------------------------------------------------- input register
  logic [ID_TO_EX_WD-1:0] id_r;

  // ID->EX register: the stall vector can insert a bubble, load a new instruction, or hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_r <= '0;
    end else if (stall[2] == STOP && stall[3] == NO_STOP) begin
      id_r <= '0;
    end else if (stall[2] == NO_STOP) begin
      id_r <= id_to_ex_bus;
    end else begin
      id_r <= id_r;
    end
  end

  logic [31:0] pc_s;
  logic [31:0] inst_s;
  logic [11:0] alu_op_s;
  logic [2:0]  sel_src1_s;
  logic [3:0]  sel_src2_s;
  logic        ram_en_s;
  logic [3:0]  ram_wen_s;
  logic        rf_we_s;
  logic [4:0]  rf_waddr_s;
  logic        sel_rf_res_s;
  logic [31:0] rdata1_s;
  logic [31:0] rdata2_s;

  assign pc_s         = id_r[158:127];
  assign inst_s       = id_r[126:95];
  assign alu_op_s     = id_r[94:83];
  assign sel_src1_s   = id_r[82:80];
  assign sel_src2_s   = id_r[79:76];
  assign ram_en_s     = id_r[75];
  assign ram_wen_s    = id_r[74:71];
  assign rf_we_s      = id_r[70];
  assign rf_waddr_s   = id_r[69:65];
  assign sel_rf_res_s = id_r[64];
  assign rdata1_s     = id_r[63:32];
  assign rdata2_s     = id_r[31:0];

  // Register-number fields and the ID/WB stall bits have no role in this stage.
  logic unused_fields_s;
  assign unused_fields_s = ^{inst_s[25:16], stall[5:4], stall[1:0]};

  // ---------------------------------------------------------------- operand select
  logic [31:0] src1_s;
  logic [31:0] src2_s;

  // First ALU operand: register, PC (for link), or shift amount field.
  always_comb begin
    src1_s = 32'h0;
    if (sel_src1_s[0]) begin
      src1_s = rdata1_s;
    end else if (sel_src1_s[1]) begin
      src1_s = pc_s;
    end else if (sel_src1_s[2]) begin
      src1_s = {27'h0, inst_s[10:6]};
    end else begin
      src1_s = 32'h0;
    end
  end

  // Second ALU operand: register, sign/zero-extended immediate, or the link offset 8.
  always_comb begin
    src2_s = 32'h0;
    if (sel_src2_s[0]) begin
      src2_s = rdata2_s;
    end else if (sel_src2_s[1]) begin
      src2_s = {{16{inst_s[15]}}, inst_s[15:0]};
    end else if (sel_src2_s[2]) begin
      src2_s = 32'd8;
    end else if (sel_src2_s[3]) begin
      src2_s = {16'h0, inst_s[15:0]};
    end else begin
      src2_s = 32'h0;
    end
  end

  // ---------------------------------------------------------------- ALU
  logic [4:0]  shamt_s;
  logic [31:0] ex_result_s;

  assign shamt_s = src1_s[4:0];

  // One-hot ALU; add/sub wrap silently, comparisons yield 0/1.
  always_comb begin
    ex_result_s = 32'h0;
    if (alu_op_s[11]) begin
      ex_result_s = src1_s + src2_s;
    end else if (alu_op_s[10]) begin
      ex_result_s = src1_s - src2_s;
    end else if (alu_op_s[9]) begin
      ex_result_s = {31'h0, ($signed(src1_s) < $signed(src2_s))};
    end else if (alu_op_s[8]) begin
      ex_result_s = {31'h0, (src1_s < src2_s)};
    end else if (alu_op_s[7]) begin
      ex_result_s = src1_s & src2_s;
    end else if (alu_op_s[6]) begin
      ex_result_s = ~(src1_s | src2_s);
    end else if (alu_op_s[5]) begin
      ex_result_s = src1_s | src2_s;
    end else if (alu_op_s[4]) begin
      ex_result_s = src1_s ^ src2_s;
    end else if (alu_op_s[3]) begin
      ex_result_s = src2_s << shamt_s;
    end else if (alu_op_s[2]) begin
      ex_result_s = src2_s >> shamt_s;
    end else if (alu_op_s[1]) begin
      ex_result_s = $signed(src2_s) >>> shamt_s;
    end else if (alu_op_s[0]) begin
      ex_result_s = {src2_s[15:0], 16'h0};
    end else begin
      ex_result_s = 32'h0;
    end
  end

  // ---------------------------------------------------------------- divider
  logic div_op_s;
  logic div_signed_s;

  assign div_op_s = (inst_s[31:26] == 6'h00) &&
                    ((inst_s[5:0] == FUNCT_DIV) || (inst_s[5:0] == FUNCT_DIVU));
  assign div_signed_s = (inst_s[5:0] == FUNCT_DIV);

  div_state_e  div_state_r;
  div_state_e  div_state_next_s;
  logic        div_load_s;
  logic        div_step_s;
  logic [4:0]  cnt_r;
  logic [63:0] remquo_r;
  logic [31:0] divisor_r;
  logic        q_neg_r;
  logic        r_neg_r;
  logic        div0_r;
  logic [31:0] dividend_raw_r;

  // Divider state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_state_r <= DIV_IDLE;
    end else begin
      div_state_r <= div_state_next_s;
    end
  end

  // Divider sequencing: load in IDLE, 32 steps in BUSY, one result cycle in DONE.
  // Losing the div instruction mid-run abandons the operation without a HI/LO write.
  always_comb begin
    div_state_next_s = div_state_r;
    div_load_s       = 1'b0;
    div_step_s       = 1'b0;
    case (div_state_r)
      DIV_IDLE: begin
        if (div_op_s) begin
          div_load_s       = 1'b1;
          div_state_next_s = DIV_BUSY;
        end else begin
          div_state_next_s = DIV_IDLE;
        end
      end
      DIV_BUSY: begin
        if (!div_op_s) begin
          div_state_next_s = DIV_IDLE;
        end else begin
          div_step_s = 1'b1;
          if (cnt_r == 5'd31) begin
            div_state_next_s = DIV_DONE;
          end else begin
            div_state_next_s = DIV_BUSY;
          end
        end
      end
      DIV_DONE: begin
        div_state_next_s = DIV_IDLE;
      end
      default: begin
        div_state_next_s = DIV_IDLE;
      end
    endcase
  end

  // Divider datapath: magnitudes and sign flags captured on load, one shift-subtract per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r          <= 5'd0;
      remquo_r       <= 64'h0;
      divisor_r      <= 32'h0;
      q_neg_r        <= 1'b0;
      r_neg_r        <= 1'b0;
      div0_r         <= 1'b0;
      dividend_raw_r <= 32'h0;
    end else if (div_load_s) begin
      cnt_r          <= 5'd0;
      remquo_r       <= {32'h0, (div_signed_s ? abs32(rdata1_s) : rdata1_s)};
      divisor_r      <= div_signed_s ? abs32(rdata2_s) : rdata2_s;
      q_neg_r        <= div_signed_s & (rdata1_s[31] ^ rdata2_s[31]);
      r_neg_r        <= div_signed_s & rdata1_s[31];
      div0_r         <= (rdata2_s == 32'h0);
      dividend_raw_r <= rdata1_s;
    end else if (div_step_s) begin
      cnt_r    <= cnt_r + 5'd1;
      remquo_r <= restore_step(remquo_r, divisor_r);
    end else begin
      cnt_r    <= cnt_r;
      remquo_r <= remquo_r;
    end
  end

  logic [31:0] div_lo_s;
  logic [31:0] div_hi_s;

  // Final HI/LO: sign-corrected quotient/remainder, or the fixed divide-by-zero pattern.
  always_comb begin
    div_lo_s = 32'h0;
    div_hi_s = 32'h0;
    if (div0_r) begin
      div_lo_s = 32'hFFFF_FFFF;
      div_hi_s = dividend_raw_r;
    end else begin
      div_lo_s = q_neg_r ? (32'h0 - remquo_r[31:0])  : remquo_r[31:0];
      div_hi_s = r_neg_r ? (32'h0 - remquo_r[63:32]) : remquo_r[63:32];
    end
  end

  // HI/LO bus is live only in the single DONE cycle.
  always_comb begin
    ex_to_hilo_bus = 66'h0;
    if (div_state_r == DIV_DONE) begin
      ex_to_hilo_bus = {1'b1, 1'b1, div_hi_s, div_lo_s};
    end else begin
      ex_to_hilo_bus = 66'h0;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign stallreq_for_ex = div_op_s & (div_state_r != DIV_DONE);

  assign ex_to_mem_bus = {pc_s, ram_en_s, ram_wen_s, sel_rf_res_s, rf_we_s, rf_waddr_s, ex_result_s};
  assign ex_to_rf_bus  = {rf_we_s, rf_waddr_s, ex_result_s};

  // Memory access is withheld while the stage is holding for the divider.
  assign data_sram_en    = ram_en_s & ~stallreq_for_ex;
  assign data_sram_wen   = ram_wen_s & {4{data_sram_en}};
  assign data_sram_addr  = ex_result_s;
  assign data_sram_wdata = rdata2_s;

  ex_stage_chk u_chk (
    .clk             (clk),
    .rst             (rst),
    .stallreq_for_ex (stallreq_for_ex),
    .hi_we           (ex_to_hilo_bus[65]),
    .lo_we           (ex_to_hilo_bus[64]),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen)
  );

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: random ALU traffic and divides against an arithmetic reference.
module tb_ex_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  s1;
    logic [3:0]  s2;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  waddr;
    logic        sel_rf_res;
    logic [31:0] r1;
    logic [31:0] r2;
  } ex_instr_t;

  logic         clk;
  logic         rst;
  logic [5:0]   stall;
  logic         stallreq_for_ex;
  logic [158:0] id_to_ex_bus;
  logic [75:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_rf_bus;
  logic [65:0]  ex_to_hilo_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .stallreq_for_ex (stallreq_for_ex),
    .id_to_ex_bus    (id_to_ex_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_rf_bus    (ex_to_rf_bus),
    .ex_to_hilo_bus  (ex_to_hilo_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [158:0] junk_bus();
    logic [159:0] j;
    j = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return j[158:0];
  endfunction

  // Reference ALU: operand choice and operation straight from the instruction fields.
  function automatic logic [31:0] model_result(input ex_instr_t t);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    int op;
    a = t.s1[0] ? t.r1 : t.s1[1] ? t.pc : t.s1[2] ? {27'd0, t.inst[10:6]} : 32'd0;
    b = t.s2[0] ? t.r2 : t.s2[1] ? {{16{t.inst[15]}}, t.inst[15:0]} :
        t.s2[2] ? 32'd8 : t.s2[3] ? {16'd0, t.inst[15:0]} : 32'd0;
    op = -1;
    for (int k = 0; k < 12; k++) begin
      if (t.alu_op[11-k]) op = k;
    end
    case (op)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3:  r = (a < b) ? 32'd1 : 32'd0;
      4:  r = a & b;
      5:  r = ~(a | b);
      6:  r = a | b;
      7:  r = a ^ b;
      8:  r = b << a[4:0];
      9:  r = b >> a[4:0];
      10: r = $signed(b) >>> a[4:0];
      11: r = {b[15:0], 16'h0000};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic ex_instr_t rand_alu();
    ex_instr_t t;
    int k;
    t = junk_bus();
    t.inst[31:26] = 6'($urandom_range(63, 1));
    k = $urandom_range(12, 0);
    t.alu_op = (k == 12) ? 12'h000 : (12'h800 >> k);
    t.s1 = 3'b001 << $urandom_range(2, 0);
    t.s2 = 4'b0001 << $urandom_range(3, 0);
    if ($urandom_range(3, 0) == 0) t.r2 = t.r1;
    return t;
  endfunction

  // Load one non-divide instruction and check every output one cycle later.
  task automatic alu_case(input ex_instr_t t, input string tag);
    logic [31:0] res;
    stall = 6'h00;
    id_to_ex_bus = t;
    tick();
    res = model_result(t);
    check_eq({tag, "_mem"}, 128'(ex_to_mem_bus),
             128'({t.pc, t.ram_en, t.ram_wen, t.sel_rf_res, t.rf_we, t.waddr, res}));
    check_eq({tag, "_rf"}, 128'(ex_to_rf_bus), 128'({t.rf_we, t.waddr, res}));
    check_eq({tag, "_sram"}, 128'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}),
             128'({t.ram_en, t.ram_wen & {4{t.ram_en}}, res, t.r2}));
    check_eq({tag, "_nostall"}, 128'({stallreq_for_ex, ex_to_hilo_bus}), 128'(67'h0));
  endtask

  // Run one DIV/DIVU the way the pipeline would: hold EX while stallreq is up.
  task automatic run_div(input logic sgn, input logic [31:0] r1, input logic [31:0] r2,
                         input string tag);
    ex_instr_t t;
    logic [31:0] lo;
    logic [31:0] hi;
    longint q;
    longint r;
    int n;
    logic early;
    logic leak;
    t = '0;
    t.pc = $urandom;
    t.inst = {6'h00, 20'($urandom), (sgn ? 6'h1A : 6'h1B)};
    t.ram_en = 1'b1;
    t.ram_wen = 4'h3;
    t.r1 = r1;
    t.r2 = r2;
    if (r2 == 32'd0) begin
      lo = 32'hFFFF_FFFF;
      hi = r1;
    end else if (sgn) begin
      q = longint'($signed(r1)) / longint'($signed(r2));
      r = longint'($signed(r1)) % longint'($signed(r2));
      lo = q[31:0];
      hi = r[31:0];
    end else begin
      lo = r1 / r2;
      hi = r1 % r2;
    end
    stall = 6'h00;
    id_to_ex_bus = t;
    tick();
    n = 0;
    early = 1'b0;
    leak = 1'b0;
    while (stallreq_for_ex === 1'b1 && n < 100) begin
      if (ex_to_hilo_bus !== 66'h0) early = 1'b1;
      if (data_sram_en !== 1'b0) leak = 1'b1;
      stall = 6'b001111;
      id_to_ex_bus = junk_bus();
      tick();
      n++;
    end
    check_eq({tag, "_stall_cycles"}, 128'(n), 128'(33));
    check_eq({tag, "_early_hilo"}, 128'({early, leak}), 128'(2'b00));
    check_eq({tag, "_hilo"}, 128'(ex_to_hilo_bus), 128'({2'b11, hi, lo}));
    check_eq({tag, "_sram_release"}, 128'({data_sram_en, data_sram_wen}), 128'(5'b1_0011));
    stall = 6'h00;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_mem"}, 128'(ex_to_mem_bus), 128'(0));
    check_eq({tag, "_rf_hilo"}, 128'({ex_to_rf_bus, ex_to_hilo_bus}), 128'(0));
    check_eq({tag, "_stallreq"}, 128'(stallreq_for_ex), 128'(0));
    check_eq({tag, "_sram"}, 128'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}),
             128'(0));
  endtask

  initial begin
    ex_instr_t t;
    logic [31:0] res;
    rst = 1'b1;
    stall = 6'h00;
    id_to_ex_bus = '0;
    repeat (2) begin
      id_to_ex_bus = junk_bus();
      tick();
    end
    check_all_zero("reset");
    rst = 1'b0;

    // ADDIU wrapping into the sign bit.
    t = '0;
    t.inst = {6'h09, 5'd1, 5'd9, 16'h0001};
    t.alu_op = 12'h800;
    t.s1 = 3'b001;
    t.s2 = 4'b0010;
    t.rf_we = 1'b1;
    t.waddr = 5'd9;
    t.r1 = 32'h7FFF_FFFF;
    alu_case(t, "addiu");
    check_eq("addiu_value", 128'(ex_to_rf_bus), 128'({1'b1, 5'd9, 32'h8000_0000}));

    // SW: address 0xF0 + 0x10.
    t = '0;
    t.inst = {6'h2B, 5'd2, 5'd3, 16'h0010};
    t.alu_op = 12'h800;
    t.s1 = 3'b001;
    t.s2 = 4'b0010;
    t.ram_en = 1'b1;
    t.ram_wen = 4'hF;
    t.r1 = 32'h0000_00F0;
    t.r2 = 32'hCAFE_F00D;
    alu_case(t, "sw");
    check_eq("sw_addr", 128'({data_sram_en, data_sram_wen, data_sram_addr}),
             128'({1'b1, 4'hF, 32'h0000_0100}));

    for (int i = 0; i < 40; i++) begin
      alu_case(rand_alu(), "alu_rand");
    end

    // Hold keeps the current instruction; bubble clears it.
    t = rand_alu();
    t.rf_we = 1'b1;
    t.ram_en = 1'b1;
    alu_case(t, "pre_hold");
    res = model_result(t);
    stall = 6'b001100;
    id_to_ex_bus = junk_bus();
    tick();
    check_eq("hold_mem", 128'(ex_to_mem_bus),
             128'({t.pc, t.ram_en, t.ram_wen, t.sel_rf_res, t.rf_we, t.waddr, res}));
    stall = 6'b000100;
    id_to_ex_bus = junk_bus();
    tick();
    check_all_zero("bubble");

    // Divides, including back-to-back issue.
    run_div(1'b0, 32'd100, 32'd7, "divu_100_7");
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_div(1'b0, 32'h0000_1234, 32'd0, "divu_by0");
    run_div(1'b1, 32'h8000_0005, 32'd0, "div_by0");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
    for (int i = 0; i < 6; i++) begin
      run_div(1'($urandom_range(1, 0)), $urandom,
              ($urandom_range(4, 0) == 0) ? 32'd0 : ($urandom >> $urandom_range(28, 0)),
              "div_rand");
    end
    id_to_ex_bus = '0;
    tick();
    check_eq("div_after_release", 128'({stallreq_for_ex, ex_to_hilo_bus}), 128'(0));

    // Reset while the divider is busy, then a fresh divide.
    t = '0;
    t.inst = {6'h00, 20'h0, 6'h1B};
    t.r1 = 32'd1000;
    t.r2 = 32'd3;
    id_to_ex_bus = t;
    tick();
    repeat (10) begin
      stall = 6'b001111;
      tick();
    end
    check_eq("busy_before_reset", 128'(stallreq_for_ex), 128'(1));
    rst = 1'b1;
    tick();
    check_all_zero("mid_busy_reset");
    rst = 1'b0;
    run_div(1'b0, 32'd1000, 32'd3, "div_after_reset");
    id_to_ex_bus = '0;
    tick();
    check_eq("final_release", 128'({stallreq_for_ex, ex_to_hilo_bus}), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
